// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_RD registered read ports,
// two write ports (port 1 wins a same-address collision) and a per-register
// busy scoreboard for pending writebacks. A reserve wins over a write to
// the same register on the same edge.
// Optional build macro RF_BYPASS_EN: when defined, a read sampled on the same
// edge as a write to that register returns the new data (write-to-read
// forwarding); when undefined, such a read returns the pre-write contents.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 64,
  parameter int NUM_RD = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD-1:0]        read_en,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rvalid,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [1:0]               write_en,
  input  logic [2*AW-1:0]          waddr,
  input  logic [2*DATA_W-1:0]      wdata,
  input  logic                     reserve_en,
  input  logic [AW-1:0]            reserve_addr
);

  logic [AW-1:0]     waddr0, waddr1;
  logic [DATA_W-1:0] wdata0, wdata1;

  assign waddr0 = waddr[0 +: AW];
  assign waddr1 = waddr[AW +: AW];
  assign wdata0 = wdata[0 +: DATA_W];
  assign wdata1 = wdata[DATA_W +: DATA_W];

  // Flop-based storage: the whole array must clear on reset.
  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  busy_reg;

  // Storage update: port 1 is applied last so it wins a collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (write_en[0]) mem_reg[waddr0] <= wdata0;
      if (write_en[1]) mem_reg[waddr1] <= wdata1;
    end
  end

  // Busy scoreboard: writeback clears, reserve sets and overrides a
  // same-edge writeback to the same register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_reg <= '0;
    end else begin
      if (write_en[0]) busy_reg[waddr0] <= 1'b0;
      if (write_en[1]) busy_reg[waddr1] <= 1'b0;
      if (reserve_en)  busy_reg[reserve_addr] <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]     ra;
      logic [DATA_W-1:0] data_next;
      logic              busy_next;
      logic [DATA_W-1:0] rdata_reg;
      logic              busy_reg_q;
      logic              rvalid_reg;

      assign ra = raddr[gi*AW +: AW];

      // Value captured by this port; optionally forwards same-edge writes.
      always_comb begin
        data_next = mem_reg[ra];
        busy_next = busy_reg[ra];
`ifdef RF_BYPASS_EN
        if (write_en[1] && (waddr1 == ra)) begin
          data_next = wdata1;
          busy_next = reserve_en && (reserve_addr == ra);
        end else if (write_en[0] && (waddr0 == ra)) begin
          data_next = wdata0;
          busy_next = reserve_en && (reserve_addr == ra);
        end
`else
        // Same-edge read sees the pre-write contents and busy bit.
`endif
      end

      // Registered read: data and busy hold while the port is idle.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rdata_reg  <= '0;
          busy_reg_q <= 1'b0;
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= read_en[gi];
          if (read_en[gi]) begin
            rdata_reg  <= data_next;
            busy_reg_q <= busy_next;
          end
        end
      end

      assign rdata[gi*DATA_W +: DATA_W] = rdata_reg;
      assign rd_busy[gi]                = busy_reg_q;
      assign rvalid[gi]                 = rvalid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp (default parameters).
// The driver keeps an array model of the register file, pushes the expected
// read result per port into a queue, and a negedge monitor pops on rvalid.
module tb_regfile_mp;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk;
  logic          reset_n;
  logic [1:0]    read_en;
  logic [2*AW-1:0] raddr;
  logic [2*DW-1:0] rdata;
  logic [1:0]    rvalid;
  logic [1:0]    rd_busy;
  logic [1:0]    write_en;
  logic [2*AW-1:0] waddr;
  logic [2*DW-1:0] wdata;
  logic          reserve_en;
  logic [AW-1:0] reserve_addr;

  regfile_mp dut (
    .clk(clk), .reset_n(reset_n), .read_en(read_en), .raddr(raddr),
    .rdata(rdata), .rvalid(rvalid), .rd_busy(rd_busy), .write_en(write_en),
    .waddr(waddr), .wdata(wdata), .reserve_en(reserve_en),
    .reserve_addr(reserve_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [DW-1:0] d;
    logic          b;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [DW-1:0] m_mem [64];
  logic          m_busy [64];
  logic [DW-1:0] last_d [2];
  logic          last_b [2];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a port presents rvalid; otherwise the
  // port must hold its last result.
  always @(negedge clk) begin
    exp_t e;
    logic empty;
    if (reset_n === 1'b1) begin
      for (int p = 0; p < 2; p++) begin
        if (rvalid[p]) begin
          empty = (p == 0) ? (q0.size() == 0) : (q1.size() == 0);
          if (empty) begin
            total++;
            bad++;
            $display("FAIL rvalid_spurious port=%0d act=1 exp=0", p);
          end else begin
            if (p == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("rdata_p%0d", p), rdata[p*DW +: DW], e.d);
            chk($sformatf("rd_busy_p%0d", p), {31'd0, rd_busy[p]}, {31'd0, e.b});
            $display("read p%0d data=%h busy=%b", p, rdata[p*DW +: DW], rd_busy[p]);
            last_d[p] = e.d;
            last_b[p] = e.b;
          end
        end else begin
          chk($sformatf("hold_rdata_p%0d", p), rdata[p*DW +: DW], last_d[p]);
          chk($sformatf("hold_busy_p%0d", p), {31'd0, rd_busy[p]}, {31'd0, last_b[p]});
        end
      end
    end
  end

  // One clock of stimulus; expectations come from the array model.
  task automatic step(input logic [1:0] ren, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                      input logic [1:0] wen, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                      input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                      input logic res, input logic [AW-1:0] resa);
    logic [DW-1:0] nm [64];
    logic          nb [64];
    logic [AW-1:0] ra;
    logic          written;
    logic          use_new;
    exp_t          e;
    @(negedge clk);
    read_en      = ren;
    raddr        = {ra1, ra0};
    write_en     = wen;
    waddr        = {wa1, wa0};
    wdata        = {wd1, wd0};
    reserve_en   = res;
    reserve_addr = resa;
    nm = m_mem;
    nb = m_busy;
    if (wen[0]) begin nm[wa0] = wd0; nb[wa0] = 1'b0; end
    if (wen[1]) begin nm[wa1] = wd1; nb[wa1] = 1'b0; end
    if (res) nb[resa] = 1'b1;
    for (int p = 0; p < 2; p++) begin
      if (ren[p]) begin
        ra = (p == 0) ? ra0 : ra1;
        written = (wen[0] && wa0 == ra) || (wen[1] && wa1 == ra);
`ifdef RF_BYPASS_EN
        use_new = written;
`else
        use_new = 1'b0;
`endif
        e.d = use_new ? nm[ra] : m_mem[ra];
        e.b = use_new ? nb[ra] : m_busy[ra];
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
    m_mem  = nm;
    m_busy = nb;
  endtask

  task automatic idle();
    step(2'b00, '0, '0, 2'b00, '0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (port == 0) step(2'b00, '0, '0, 2'b01, a, '0, d, '0, 1'b0, '0);
    else           step(2'b00, '0, '0, 2'b10, '0, a, '0, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [1:0] ren, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    step(ren, a0, a1, 2'b00, '0, '0, '0, '0, 1'b0, '0);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    reset_n      = 1'b0;
    read_en      = '0;
    raddr        = '0;
    write_en     = '0;
    waddr        = '0;
    wdata        = '0;
    reserve_en   = 1'b0;
    reserve_addr = '0;
    q0.delete();
    q1.delete();
    for (int i = 0; i < 64; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      last_d[p] = '0;
      last_b[p] = 1'b0;
    end
    #1;
    chk("reset_rdata_p0", rdata[31:0], 32'd0);
    chk("reset_rdata_p1", rdata[63:32], 32'd0);
    chk("reset_rvalid", {30'd0, rvalid}, 32'd0);
    chk("reset_busy", {30'd0, rd_busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [AW-1:0] raddr_pick();
    logic [AW-1:0] a;
    if ($urandom_range(0, 1) == 1) a = AW'($urandom_range(0, 7));
    else                           a = AW'($urandom_range(0, 63));
    return a;
  endfunction

  initial begin
    logic [DW-1:0] d;
    reset_n = 1'b1;
    #3;
    do_reset();

    // All addresses read zero after reset, both ports.
    for (int i = 0; i < 64; i++) rd(2'b11, AW'(i), AW'(63 - i));

    // Sweep: write via each port, read individually and simultaneously.
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      wr(0, AW'(i), d);
      rd(2'b01, AW'(i), '0);
      rd(2'b10, '0, AW'(i));
      d = $urandom;
      wr(1, AW'(i), d);
      rd(2'b11, AW'(i), AW'(i));
    end

    // Write collision: port 1 wins.
    step(2'b00, '0, '0, 2'b11, 6'h05, 6'h05, 32'hAAAA_0000, 32'h5555_FFFF, 1'b0, '0);
    rd(2'b11, 6'h05, 6'h05);

    // Same-edge write and read (result depends on RF_BYPASS_EN).
    wr(0, 6'h0A, 32'h1111_1111);
    step(2'b01, 6'h0A, '0, 2'b01, 6'h0A, '0, 32'h2222_2222, '0, 1'b0, '0);
    rd(2'b11, 6'h0A, 6'h0A);

    // Busy scoreboard.
    step(2'b00, '0, '0, 2'b00, '0, '0, '0, '0, 1'b1, 6'h10);
    rd(2'b01, 6'h10, '0);
    wr(0, 6'h10, 32'h0000_1010);
    rd(2'b10, '0, 6'h10);
    step(2'b11, 6'h11, 6'h11, 2'b10, '0, 6'h11, '0, 32'h0000_1111, 1'b1, 6'h11);
    rd(2'b11, 6'h11, 6'h11);

    // Randomised traffic concentrated on a few low addresses.
    for (int n = 0; n < 400; n++) begin
      step(2'($urandom), raddr_pick(), raddr_pick(), 2'($urandom), raddr_pick(), raddr_pick(),
           $urandom, $urandom, 1'($urandom), raddr_pick());
    end

    // Reset in the middle of traffic.
    wr(0, 6'h3F, 32'hDEAD_BEEF);
    rd(2'b11, 6'h3F, 6'h3F);
    idle();
    @(posedge clk);
    #2;
    do_reset();
    rd(2'b11, 6'h3F, 6'h3F);

    repeat (3) idle();
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
